// File: rtl/pc_reg_stack.sv
// Program-counter register with load/increment/clear, configurable step,
// wrap-or-saturate increment, and a return-address stack for CALL/RET.
module pc_reg_stack #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int DEPTH = 4,
  parameter int WRAP  = 1
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       CLR,
  input  logic                       LD,
  input  logic                       INR,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       COUT,
  output logic [$clog2(DEPTH+1)-1:0] SP,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);
  localparam logic [SPW-1:0]   DEPTH_W = SPW'(DEPTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Stack storage is left unreset; entries above SP are never observed.
  logic [WIDTH-1:0] stack_mem [2**AW];
  logic             push_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [SPW-1:0]   sp_minus1;
  logic [WIDTH-1:0] stack_top;

  logic [WIDTH:0]   sum;
  logic             full, empty;

  assign sum       = {1'b0, q_q} + STEP_W;
  assign full      = (sp_q == DEPTH_W);
  assign empty     = (sp_q == '0);
  assign sp_minus1 = sp_q - SPW'(1);
  assign wr_addr   = sp_q[AW-1:0];
  assign rd_addr   = sp_minus1[AW-1:0];
  // Asynchronous read so RET can land the return address in Q on the next edge.
  assign stack_top = stack_mem[rd_addr];

  always_comb begin
    q_d     = q_q;
    sp_d    = sp_q;
    cout_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (CLR) begin
      q_d   = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (CALL) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SPW'(1);
        q_d     = D;
      end
    end else if (RET) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        q_d  = stack_top;
        sp_d = sp_minus1;
      end
    end else if (LD) begin
      q_d = D;
    end else if (INR) begin
      cout_d = sum[WIDTH];
      if ((WRAP == 0) && sum[WIDTH]) begin
        q_d = '1;
      end else begin
        q_d = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      q_q    <= '0;
      sp_q   <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      sp_q   <= sp_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // The return address always wraps, independent of the INR saturation mode.
  always_ff @(posedge CLK) begin
    if (RSTn && !CLR && push_en) begin
      stack_mem[wr_addr] <= sum[WIDTH-1:0];
    end
  end

  assign Q     = q_q;
  assign COUT  = cout_q;
  assign SP    = sp_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule
